// File: rtl/result_unloader.sv
// result_unloader: reads NUM_WORDS result words from the result RAM, starting at BASE_ADDR,
// and streams them off-chip over a valid/ack handshake. Each word takes one READ cycle, one
// WAIT cycle for the RAM latency and at least one SEND cycle. doneUnloading stays high
// after the final transfer until the next start.
module result_unloader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_WORDS  = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ramRead,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  input  logic [DATA_WIDTH-1:0] ramData,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outAck,
  output logic                  busy,
  output logic                  doneUnloading
);

  localparam int unsigned CNT_WIDTH = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StSend,
    StDone
  } state_e;

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_next;

  // Address of the following word; the parameter bounds guarantee it never wraps.
  assign addr_next = addr_q + ADDR_WIDTH'(1);

  // Control FSM; every output is a register updated on the transition into its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= BASE;
      ramRead       <= 1'b0;
      ramAddr       <= '0;
      outData       <= '0;
      outValid      <= 1'b0;
      busy          <= 1'b0;
      doneUnloading <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q       <= StRead;
            cnt_q         <= '0;
            addr_q        <= BASE;
            ramRead       <= 1'b1;
            ramAddr       <= BASE;
            busy          <= 1'b1;
            doneUnloading <= 1'b0;
          end
        end
        StRead: begin
          ramRead <= 1'b0;
          state_q <= StWait;
        end
        StWait: begin
          // RAM data for the address issued in READ is valid now.
          outData  <= ramData;
          outValid <= 1'b1;
          state_q  <= StSend;
        end
        StSend: begin
          if (outAck) begin
            outValid <= 1'b0;
            if (cnt_q == LAST_CNT) begin
              state_q       <= StDone;
              busy          <= 1'b0;
              doneUnloading <= 1'b1;
            end else begin
              state_q <= StRead;
              cnt_q   <= cnt_q + CNT_WIDTH'(1);
              addr_q  <= addr_next;
              ramRead <= 1'b1;
              ramAddr <= addr_next;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          ramRead  <= 1'b0;
          outValid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_unloader.sv
// Bench for result_unloader: a default instance (10 words from address 0) checked through a
// data/address scoreboard, plus a NUM_WORDS=1, BASE_ADDR=1023 instance checked directly.
module tb_result_unloader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, outAck;
  logic        ramRead, outValid, busy, doneUnloading;
  logic [9:0]  ramAddr;
  logic [15:0] ramData, outData;

  logic        start1, outAck1;
  logic        ramRead1, outValid1, busy1, doneUnloading1;
  logic [9:0]  ramAddr1;
  logic [15:0] ramData1, outData1;

  logic [15:0] mem [0:1023];
  logic [15:0] exp_data [$];
  logic [9:0]  exp_addr [$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int t;

  logic        hold_pending = 1'b0;
  logic [15:0] hold_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Synchronous-read RAM model, one read port per instance.
  always @(posedge clk) begin
    if (ramRead)  ramData  <= mem[ramAddr];
    if (ramRead1) ramData1 <= mem[ramAddr1];
  end

  result_unloader dut (
    .clk(clk), .rst(rst), .start(start), .ramRead(ramRead), .ramAddr(ramAddr),
    .ramData(ramData), .outData(outData), .outValid(outValid), .outAck(outAck),
    .busy(busy), .doneUnloading(doneUnloading)
  );

  result_unloader #(.NUM_WORDS(1), .BASE_ADDR(1023)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ramRead(ramRead1), .ramAddr(ramAddr1),
    .ramData(ramData1), .outData(outData1), .outValid(outValid1), .outAck(outAck1),
    .busy(busy1), .doneUnloading(doneUnloading1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: scoreboard for transfers and reads, plus data stability under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (ramRead) begin
        if (exp_addr.size() == 0) chk("unexpected_read", 32'(ramAddr), 32'h0);
        else chk("ram_addr", 32'(ramAddr), 32'(exp_addr.pop_front()));
      end
      if (hold_pending && outValid) chk("data_stable", 32'(outData), 32'(hold_data));
      if (outValid && outAck) begin
        if (exp_data.size() == 0) chk("unexpected_word", 32'(outData), 32'h0);
        else chk("word", 32'(outData), 32'(exp_data.pop_front()));
      end
      hold_pending = outValid && !outAck;
      hold_data    = outData;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run();
    for (int i = 0; i < 10; i++) begin
      exp_data.push_back(mem[i]);
      exp_addr.push_back(10'(i));
    end
  endtask

  // Returns the edge number at which start was sampled.
  task automatic start_pulse(output int ts);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    ts = cyc;
  endtask

  task automatic wait_done(input int ts, input int lat, input string name);
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (doneUnloading) break;
    end
    if (n == 200) chk({name, "_timeout"}, 32'(doneUnloading), 32'h1);
    else if (lat >= 0) chk({name, "_latency"}, 32'(cyc - ts), 32'(lat));
    chk({name, "_busy_low"}, 32'(busy), 32'h0);
    chk({name, "_words_left"}, 32'(exp_data.size()), 32'h0);
    chk({name, "_reads_left"}, 32'(exp_addr.size()), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; outAck = 1'b1; start1 = 1'b0; outAck1 = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    for (int i = 0; i < 10; i++) mem[i] = 16'h0100 + 16'(i);
    mem[1023] = 16'hBEEF;
    #1;
    chk("reset_outputs", {ramRead, ramAddr, outData, outValid, busy, doneUnloading}, 32'h0);
    chk("reset_outputs1", {ramRead1, ramAddr1, outData1, outValid1, busy1, doneUnloading1},
        32'h0);
    step(); step();
    rst = 1'b0;

    // Basic unload with outAck tied high.
    push_run();
    start_pulse(t);
    wait_done(t, 30, "basic");

    // Starts while busy are ignored; timing unchanged.
    push_run();
    start_pulse(t);
    while (cyc < t + 6) step();
    start = 1'b1; step(); start = 1'b0;
    while (cyc < t + 23) step();
    start = 1'b1; step(); start = 1'b0;
    wait_done(t, 30, "ignored_start");

    // Backpressure with roughly 30% ack duty.
    push_run();
    start_pulse(t);
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1 outAck = ($urandom_range(0, 9) < 3);
      @(negedge clk);
      if (doneUnloading) break;
    end
    outAck = 1'b1;
    chk("backpressure_done", 32'(doneUnloading), 32'h1);
    chk("backpressure_words_left", 32'(exp_data.size()), 32'h0);

    // Restart from DONE with new RAM contents.
    for (int i = 0; i < 10; i++) mem[i] = 16'hA000 + 16'(i);
    push_run();
    start_pulse(t);
    @(negedge clk);
    chk("restart_done_drop", 32'(doneUnloading), 32'h0);
    chk("restart_busy", 32'(busy), 32'h1);
    wait_done(t, 30, "restart");

    // Reset while word 4 sits in SEND.
    push_run();
    start_pulse(t);
    while (cyc < t + 14) step();
    outAck = 1'b0;
    @(negedge clk);
    chk("pre_reset_send", {outValid, outData}, {15'h0, 1'b1, 16'hA004});
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {ramRead, ramAddr, outData, outValid, busy, doneUnloading},
        32'h0);
    exp_data.delete();
    exp_addr.delete();
    step();
    rst = 1'b0;
    outAck = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_quiet", {ramRead, outValid, busy, doneUnloading}, 32'h0);
    end
    push_run();
    start_pulse(t);
    wait_done(t, 30, "after_reset");

    // Single-word instance at the top of the address space.
    step();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    t = cyc;
    @(negedge clk);
    chk("edge_read", {ramRead1, ramAddr1}, {21'h0, 1'b1, 10'd1023});
    @(negedge clk);
    chk("edge_wait", {ramRead1, outValid1}, 32'h0);
    @(negedge clk);
    chk("edge_send", {outValid1, outData1}, {15'h0, 1'b1, 16'hBEEF});
    @(negedge clk);
    chk("edge_done", {doneUnloading1, busy1, outValid1}, 32'h4);
    chk("edge_latency", 32'(cyc - t), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
